// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 encodings,
// FSM state type and the size/legality decode used at request acceptance.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  // Byte count of an access; funct3[1:0] == 11 is always illegal, so its value is unused.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word according to funct3.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_BU:   result = {24'h000000, word[7:0]};
      F3_HU:   result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/byte_mem_access_unit.sv
// Serialises one load/store request into 1/2/4 little-endian byte accesses on an
// 8-bit memory port and returns the extended load result with a done pulse.
module byte_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [2:0]            mem_src,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic [7:0]            bmem_wdata,
  output logic                  bmem_we,
  output logic                  bmem_re,
  input  logic [7:0]            bmem_rdata,
  output mem_state_t            state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the requester must hold its fields until then.

  mem_state_t            state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [2:0]            f3_q;
  logic [2:0]            size_q;
  logic [1:0]            idx_q;
  logic                  illegal_q;
  logic                  pend_q;
  logic [1:0]            pend_lane_q;
  logic [31:0]           word_q;
  logic [31:0]           assembled;
  logic [31:0]           ext_word;
  logic                  accept;
  logic                  req_legal;
  logic                  issuing;
  logic                  last_byte;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_WIDTH];

  assign accept    = req_valid && req_ready;
  assign req_legal = is_legal(mem_write, mem_src);
  assign issuing   = (state == ISSUE);
  assign last_byte = ({1'b0, idx_q} == (size_q - 3'd1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_legal ? ISSUE : RESP;
      ISSUE:   if (last_byte) state_next = write_q ? RESP : DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    done       = (state == RESP);
    err        = (state == RESP) && illegal_q;
    bmem_we    = issuing && write_q;
    bmem_re    = issuing && !write_q;
    bmem_addr  = '0;
    bmem_wdata = 8'h00;
    if (issuing) begin
      bmem_addr = base_q + ADDR_WIDTH'(idx_q);
    end
    if (bmem_we) begin
      bmem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
    end
  end

  // The byte read in the previous cycle is merged here so the DRAIN edge sees the full word.
  always_comb begin
    assembled = word_q;
    if (pend_q) begin
      assembled[{pend_lane_q, 3'b000} +: 8] = bmem_rdata;
    end
  end

  load_extend u_load_extend (
    .word   (assembled),
    .funct3 (f3_q),
    .result (ext_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      write_q     <= 1'b0;
      f3_q        <= 3'b000;
      size_q      <= 3'd1;
      idx_q       <= 2'd0;
      illegal_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_lane_q <= 2'd0;
      word_q      <= 32'h0;
      rdata       <= 32'h0;
    end else begin
      state       <= state_next;
      pend_q      <= issuing && !write_q;
      pend_lane_q <= idx_q;
      if (pend_q) begin
        word_q <= assembled;
      end
      if (issuing) begin
        idx_q <= idx_q + 2'd1;
      end
      if (accept) begin
        base_q    <= addr[ADDR_WIDTH-1:0];
        wdata_q   <= wdata;
        write_q   <= mem_write;
        f3_q      <= mem_src;
        size_q    <= access_size(mem_src);
        idx_q     <= 2'd0;
        illegal_q <= !req_legal;
        word_q    <= 32'h0;
        if (!req_legal) begin
          rdata <= 32'h0;
        end
      end
      if (state == DRAIN) begin
        rdata <= ext_word;
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_access_unit.sv
// Bench for byte_mem_access_unit: byte memory responder, request-level reference
// model with per-cycle compare, directed literal cases and randomized traffic.
module tb_byte_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW        = 17;
  localparam int MEM_BYTES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          mem_write = 1'b0;
  logic [2:0]    mem_src = 3'b000;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          done;
  logic          err;
  logic [AW-1:0] bmem_addr;
  logic [7:0]    bmem_wdata;
  logic          bmem_we;
  logic          bmem_re;
  logic [7:0]    bmem_rdata = 8'h00;
  mem_state_t    state;

  always #5 clk = ~clk;

  byte_mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_write  (mem_write),
    .mem_src    (mem_src),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .err        (err),
    .bmem_addr  (bmem_addr),
    .bmem_wdata (bmem_wdata),
    .bmem_we    (bmem_we),
    .bmem_re    (bmem_re),
    .bmem_rdata (bmem_rdata),
    .state      (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte memory the DUT talks to, plus activity counters.
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  int re_count = 0;
  int we_count = 0;
  int done_count = 0;

  always @(posedge clk) begin
    if (bmem_we) mem[bmem_addr] <= bmem_wdata;
    if (bmem_re) bmem_rdata <= mem[bmem_addr];
    if (bmem_re) re_count++;
    if (bmem_we) we_count++;
    if (done) done_count++;
  end

  // Reference model: request-level view of legality, size, latency and result.
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_legal(input logic w, input logic [2:0] f3);
    if (w) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] ref_load(input int base, input logic [2:0] f3);
    logic [31:0] u;
    u = 32'h0;
    for (int k = 0; k < ref_size(f3); k++) begin
      u = u + (32'(ref_mem[(base + k) % MEM_BYTES]) << (8 * k));
    end
    if (f3 == 3'd0 && u >= 32'd128)   u = u - 32'd256;
    if (f3 == 3'd1 && u >= 32'd32768) u = u - 32'd65536;
    return u;
  endfunction

  logic [31:0] exp_q[$];
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_lat = 0;
  int          m_n = 0;
  bit          m_write = 1'b0;
  bit          m_legal = 1'b1;
  int          m_base = 0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_rdata = 32'h0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_age == m_lat) m_busy = 1'b0;
      else m_age++;
      if (m_busy && m_age == m_lat) m_rdata = m_result;
    end else if (req_valid) begin
      m_busy  = 1'b1;
      m_age   = 1;
      m_write = mem_write;
      m_legal = ref_legal(mem_write, mem_src);
      m_n     = ref_size(mem_src);
      m_base  = int'(addr[AW-1:0]);
      m_wdata = wdata;
      if (!m_legal) begin
        m_lat    = 1;
        m_result = 32'h0;
      end else if (mem_write) begin
        m_lat    = 1 + m_n;
        m_result = m_rdata;
        for (int k = 0; k < m_n; k++) ref_mem[(m_base + k) % MEM_BYTES] = 8'(wdata >> (8 * k));
      end else begin
        m_lat    = 2 + m_n;
        m_result = ref_load(m_base, mem_src);
      end
      exp_q.push_back(m_result);
      if (m_lat == 1) m_rdata = m_result;
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_done;
      bit issuing;
      exp_done = m_busy && (m_age == m_lat);
      issuing  = m_busy && m_legal && (m_age <= m_n);
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("done", 32'(done), 32'(exp_done));
      check("err", 32'(err), 32'(exp_done && !m_legal));
      check("rdata_hold", rdata, m_rdata);
      check("we_re_exclusive", 32'(bmem_we & bmem_re), 32'h0);
      check("bmem_we", 32'(bmem_we), 32'(issuing && m_write));
      check("bmem_re", 32'(bmem_re), 32'(issuing && !m_write));
      if (issuing) check("bmem_addr", 32'(bmem_addr), 32'((m_base + m_age - 1) % MEM_BYTES));
      if (issuing && m_write) check("bmem_wdata", 32'(bmem_wdata), 32'(8'(m_wdata >> (8 * (m_age - 1)))));
      if (exp_done) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 32'(exp_q.size()), 32'h1);
        else check("resp_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic present(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int guard;
    @(negedge clk);
    mem_write = w;
    mem_src   = f3;
    addr      = a;
    wdata     = d;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    check("done_seen", 32'(done), 32'h1);
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    present(w, f3, a, d);
    req_valid = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int lat2;
    int r0;
    int w0;
    int d0;
    for (int k = 0; k < MEM_BYTES; k++) begin
      mem[k]     = 8'($urandom);
      ref_mem[k] = mem[k];
    end
    mem[32'h100] = 8'h80; mem[32'h101] = 8'h7F; mem[32'h102] = 8'h12; mem[32'h103] = 8'h34;
    for (int k = 32'h100; k < 32'h104; k++) ref_mem[k] = mem[k];

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_we", 32'(bmem_we), 32'h0);
    check("rst_re", 32'(bmem_re), 32'h0);
    check("rst_addr", 32'(bmem_addr), 32'h0);
    check("rst_wdata", 32'(bmem_wdata), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    r0 = re_count;
    do_req(1'b0, F3_B, 32'h100, 32'h0, lat);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_latency", 32'(lat), 32'd3);
    check("lb_re_count", 32'(re_count - r0), 32'd1);
    do_req(1'b0, F3_BU, 32'h100, 32'h0, lat);
    check("lbu_rdata", rdata, 32'h00000080);
    do_req(1'b0, F3_H, 32'h100, 32'h0, lat);
    check("lh_rdata", rdata, 32'h00007F80);
    check("lh_latency", 32'(lat), 32'd4);
    do_req(1'b0, F3_W, 32'h100, 32'h0, lat);
    check("lw_rdata", rdata, 32'h34127F80);
    check("lw_latency", 32'(lat), 32'd6);

    do_req(1'b1, F3_W, 32'h0001FFFE, 32'hDEADBEEF, lat);
    check("sw_latency", 32'(lat), 32'd5);
    check("sw_rdata_kept", rdata, 32'h34127F80);
    check("sw_byte0", 32'(mem[32'h1FFFE]), 32'hEF);
    check("sw_byte1", 32'(mem[32'h1FFFF]), 32'hBE);
    check("sw_byte2_wrap", 32'(mem[0]), 32'hAD);
    check("sw_byte3_wrap", 32'(mem[1]), 32'hDE);

    do_req(1'b1, F3_H, 32'h101, 32'h0000ABCD, lat);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_lo", 32'(mem[32'h101]), 32'hCD);
    check("sh_hi", 32'(mem[32'h102]), 32'hAB);
    check("sh_below_intact", 32'(mem[32'h100]), 32'h80);
    check("sh_above_intact", 32'(mem[32'h103]), 32'h34);
    do_req(1'b0, F3_HU, 32'h101, 32'h0, lat);
    check("lhu_mis_rdata", rdata, 32'h0000ABCD);
    do_req(1'b0, F3_H, 32'h101, 32'h0, lat);
    check("lh_mis_rdata", rdata, 32'hFFFFABCD);

    r0 = re_count; w0 = we_count;
    do_req(1'b0, 3'b011, 32'h100, 32'h0, lat);
    check("ill_load_err", 32'(err), 32'h1);
    check("ill_load_latency", 32'(lat), 32'd1);
    check("ill_load_rdata", rdata, 32'h0);
    do_req(1'b1, 3'b100, 32'h100, 32'h12345678, lat);
    check("ill_store_err", 32'(err), 32'h1);
    check("ill_store_latency", 32'(lat), 32'd1);
    check("ill_store_rdata", rdata, 32'h0);
    check("ill_no_strobes", 32'((re_count - r0) + (we_count - w0)), 32'h0);

    // Reset lands on the second ISSUE cycle of a word load.
    present(1'b0, F3_W, 32'h100, 32'h0);
    req_valid = 1'b0;
    r0 = re_count; d0 = done_count;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'h1);
    repeat (6) @(negedge clk);
    check("abort_re_count", 32'(re_count - r0), 32'd2);
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    do_req(1'b0, F3_B, 32'h100, 32'h0, lat);
    check("post_abort_lb", rdata, 32'hFFFFFF80);
    check("post_abort_lat", 32'(lat), 32'd3);

    // Back-to-back: request held across two word loads.
    @(negedge clk);
    r0 = re_count;
    present(1'b0, F3_W, 32'h100, 32'h0);
    wait_done(lat);
    wait_done(lat2);
    req_valid = 1'b0;
    check("b2b_first_lat", 32'(lat), 32'd6);
    check("b2b_second_gap", 32'(lat2), 32'd7);
    check("b2b_re_count", 32'(re_count - r0), 32'd8);

    for (int t = 0; t < 60; t++) begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8 && !ref_legal(w, f3)) f3 = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       a = 32'h0001FFFC + 32'($urandom_range(0, 3));
        1:       a = 32'h100 + 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      do_req(w, f3, a, $urandom, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
